clock_mode_ctrl: RTL and testbench
==================================

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20: cycles a synchronized button must hold a new level before the debounced level changes.
REQ-002 SHALL have parameter REPEAT_DELAY_MS, default 500: cycles from an inc press to its first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE_MS, default 100: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter EDIT_TIMEOUT_MS, default 10000: idle cycles in EDIT before automatic return to RUN.
REQ-005 SHALL have port clk_1kHz, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports BTN_mode, BTN_edit, BTN_inc_h, BTN_inc_m, input, 1 each: raw asynchronous push buttons, active-high.
REQ-008 SHALL have port mode, output, 2: selected clock mode for the datapaths (00, 01, 10, 11).
REQ-009 SHALL have port edit, output, 1: 1 while in EDIT state.
REQ-010 SHALL have ports inc_h, inc_m, output, 1 each: single-cycle increment strobes to the hour/minute datapaths.
REQ-011 SHALL have port mode_chg, output, 1: single-cycle strobe in the cycle mode takes a new value.

Function
REQ-012 Each BTN_* SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button, a debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, clear to 0 when equal, and on reaching DEBOUNCE_MS load the synchronized level into the debounced level and clear.
REQ-014 A press SHALL be the 0->1 transition of a debounced level; release events generate nothing.
REQ-015 A clean raw rising edge SHALL yield its press event DEBOUNCE_MS+2 cycles after the first clk_1kHz edge sampling it high; glitches shorter than DEBOUNCE_MS cycles SHALL yield no event.
REQ-016 Control FSM SHALL have states RUN and EDIT; edit = (state == EDIT).
REQ-017 RUN: edit press -> EDIT next cycle; mode press -> mode = mode+1 modulo 4 (11 wraps to 00) and mode_chg=1 for that cycle.
REQ-018 RUN and EDIT: simultaneous edit and mode press -> edit press acts, mode press dropped.
REQ-019 EDIT: edit press -> RUN; mode presses ignored; mode SHALL not change while edit=1.
REQ-020 EDIT: inc_h press SHALL drive inc_h=1 for exactly one cycle, registered, in the cycle after the press event; same for inc_m; both strobes MAY assert in the same cycle.
REQ-021 EDIT: while a debounced inc button stays high, a repeat pulse SHALL occur REPEAT_DELAY_MS cycles after its press strobe, then every REPEAT_RATE_MS cycles until release or exit from EDIT.
REQ-022 RUN: inc presses and repeats SHALL be discarded; inc_h=inc_m=0.
REQ-023 EDIT: idle counter SHALL clear on entry and on any press event; on reaching EDIT_TIMEOUT_MS -> RUN; held-button repeats SHALL also clear it.
REQ-024 Exit from EDIT SHALL cancel pending repeats; an inc button still held on re-entry SHALL produce no strobe until released and pressed again.
REQ-025 All counters SHALL saturate/clear as stated and never wrap silently; widths sized by $clog2 of their parameter+1.

Reset
REQ-026 reset=1 SHALL immediately force state=RUN, mode=00, edit=0, inc_h=inc_m=mode_chg=0, clear all synchronizers, debounced levels (0) and counters, regardless of operation in progress.
REQ-027 After reset release, a button already held SHALL register as one press after DEBOUNCE_MS+2 cycles.

Verification (bench params DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3, EDIT_TIMEOUT_MS=50)
REQ-028 Reset, press BTN_mode 4 times (each held 8 cycles) -> mode 01,10,11,00, one mode_chg per step, edit=0 throughout.
REQ-029 BTN_inc_h 2-cycle glitch in EDIT -> no inc_h; clean press -> exactly one inc_h strobe 7 cycles after raw rise (6 to press event + 1 register).
REQ-030 EDIT, hold BTN_inc_m 30 cycles -> strobes at press, +10, +13, +16, ... then none after release; mode press meanwhile -> mode unchanged.
REQ-031 Enter EDIT, no activity -> edit falls 50 cycles after entry; inc press in RUN -> no strobe.
REQ-032 Simultaneous BTN_edit and BTN_mode press in RUN -> edit=1, mode unchanged; assert reset mid-hold -> all outputs 0, mode=00 same cycle.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - button debounce and RUN/EDIT control FSM for a clock with auto-repeat increments
`timescale 1ns/1ps
module clock_mode_ctrl #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int EDIT_TIMEOUT_MS = 10000
) (
    input  logic       clk_1kHz,
    input  logic       reset,
    input  logic       BTN_mode,
    input  logic       BTN_edit,
    input  logic       BTN_inc_h,
    input  logic       BTN_inc_m,
    output logic [1:0] mode,
    output logic       edit,
    output logic       inc_h,
    output logic       inc_m,
    output logic       mode_chg
);
    localparam int DW   = $clog2(DEBOUNCE_MS + 1);
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int IW   = $clog2(EDIT_TIMEOUT_MS + 1);

    typedef enum logic {RUN, EDIT} state_t;

    // bit order everywhere: {inc_m, inc_h, edit, mode}
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
    logic [DW-1:0] dcnt_q [4];

    assign raw = {BTN_inc_m, BTN_inc_h, BTN_edit, BTN_mode};

    always_ff @(posedge clk_1kHz or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
                    deb_q[i]  <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t        state_q;
    logic [1:0]    mode_q;
    logic          edit_q, mode_chg_q;
    logic [1:0]    inc_q, rep_on_q, rep_first_q, rep_hit;
    logic [RW-1:0] rep_cnt_q [2];
    logic [IW-1:0] idle_q;

    // repeat fires while the debounced level is still high at the hit cycle
    always_comb begin
        rep_hit = '0;
        for (int j = 0; j < 2; j++)
            rep_hit[j] = rep_on_q[j] && deb_q[j+2] &&
                         (rep_cnt_q[j] == (rep_first_q[j] ? RW'(REPEAT_DELAY_MS - 1)
                                                          : RW'(REPEAT_RATE_MS - 1)));
    end

    always_ff @(posedge clk_1kHz or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            mode_q      <= 2'b00;
            edit_q      <= 1'b0;
            mode_chg_q  <= 1'b0;
            inc_q       <= '0;
            rep_on_q    <= '0;
            rep_first_q <= '0;
            idle_q      <= '0;
            for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
        end else begin
            mode_chg_q <= 1'b0;
            inc_q      <= '0;
            case (state_q)
                RUN: begin
                    rep_on_q <= '0;
                    if (press_q[1]) begin
                        state_q <= EDIT;
                        edit_q  <= 1'b1;
                        idle_q  <= '0;
                    end else if (press_q[0]) begin
                        mode_q     <= mode_q + 2'd1;
                        mode_chg_q <= 1'b1;
                    end
                end
                EDIT: begin
                    if (press_q[1]) begin
                        state_q  <= RUN;
                        edit_q   <= 1'b0;
                        rep_on_q <= '0;
                    end else if ((|press_q) || (|rep_hit)) begin
                        idle_q <= '0;
                    end else if (idle_q == IW'(EDIT_TIMEOUT_MS - 1)) begin
                        state_q  <= RUN;
                        edit_q   <= 1'b0;
                        rep_on_q <= '0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                    if (!press_q[1]) begin
                        for (int j = 0; j < 2; j++) begin
                            if (press_q[j+2]) begin
                                inc_q[j]       <= 1'b1;
                                rep_on_q[j]    <= 1'b1;
                                rep_first_q[j] <= 1'b1;
                                rep_cnt_q[j]   <= '0;
                            end else if (rep_hit[j]) begin
                                inc_q[j]       <= 1'b1;
                                rep_first_q[j] <= 1'b0;
                                rep_cnt_q[j]   <= '0;
                            end else if (rep_on_q[j] && deb_q[j+2]) begin
                                rep_cnt_q[j] <= rep_cnt_q[j] + 1'b1;
                            end else begin
                                rep_on_q[j] <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign mode     = mode_q;
    assign edit     = edit_q;
    assign inc_h    = inc_q[0];
    assign inc_m    = inc_q[1];
    assign mode_chg = mode_chg_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed table-driven bench for clock_mode_ctrl
`timescale 1ns/1ps
module tb_clock_mode_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       b_mode, b_edit, b_inc_h, b_inc_m;
    logic [1:0] mode;
    logic       edit, inc_h, inc_m, mode_chg;

    int n_cmp = 0;
    int n_bad = 0;

    clock_mode_ctrl #(
        .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(3), .EDIT_TIMEOUT_MS(50)
    ) dut (
        .clk_1kHz(clk), .reset(reset),
        .BTN_mode(b_mode), .BTN_edit(b_edit), .BTN_inc_h(b_inc_h), .BTN_inc_m(b_inc_m),
        .mode(mode), .edit(edit), .inc_h(inc_h), .inc_m(inc_m), .mode_chg(mode_chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] btn;        // {inc_m, inc_h, edit, mode}
        logic [1:0] exp_mode;
        logic       exp_edit;
        int         exp_chg;
        int         exp_inc;
        int         exp_ehi;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {b_inc_m, b_inc_h, b_edit, b_mode} = b;
    endtask

    // press, hold 8 cycles, release, observe 20 cycles total
    task automatic press_window(input logic [3:0] b, output int chg, output int inc, output int ehi);
        chg = 0; inc = 0; ehi = 0;
        set_btn(b);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 8) set_btn(4'b0000);
            chg += int'(mode_chg);
            inc += int'(inc_h) + int'(inc_m);
            ehi += int'(edit);
        end
    endtask

    initial begin
        int chg, inc, ehi, n_inc, rise_at, fall_at;
        logic exp_m;

        vecs[0]  = '{"mode1",     4'b0001, 2'b01, 1'b0, 1, 0, 0};
        vecs[1]  = '{"mode2",     4'b0001, 2'b10, 1'b0, 1, 0, 0};
        vecs[2]  = '{"mode3",     4'b0001, 2'b11, 1'b0, 1, 0, 0};
        vecs[3]  = '{"mode_wrap", 4'b0001, 2'b00, 1'b0, 1, 0, 0};
        vecs[4]  = '{"edit_in",   4'b0010, 2'b00, 1'b1, 0, 0, 13};
        vecs[5]  = '{"mode_edit", 4'b0001, 2'b00, 1'b1, 0, 0, 20};
        vecs[6]  = '{"edit_out",  4'b0010, 2'b00, 1'b0, 0, 0, 7};
        vecs[7]  = '{"edit_mode", 4'b0011, 2'b00, 1'b1, 0, 0, 13};
        vecs[8]  = '{"edit_out2", 4'b0010, 2'b00, 1'b0, 0, 0, 7};
        vecs[9]  = '{"inc_run",   4'b0100, 2'b00, 1'b0, 0, 0, 0};
        vecs[10] = '{"mode_pre",  4'b0001, 2'b01, 1'b0, 1, 0, 0};

        reset = 1'b1;
        set_btn(4'b0000);
        repeat (3) tick();
        chk("rst_mode", 32'(mode), 0);
        chk("rst_outs", 32'({edit, inc_h, inc_m, mode_chg}), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            press_window(vecs[i].btn, chg, inc, ehi);
            chk({vecs[i].name, "_mode"}, 32'(mode), 32'(vecs[i].exp_mode));
            chk({vecs[i].name, "_edit"}, 32'(edit), 32'(vecs[i].exp_edit));
            chk({vecs[i].name, "_chg"}, 32'(chg), 32'(vecs[i].exp_chg));
            chk({vecs[i].name, "_inc"}, 32'(inc), 32'(vecs[i].exp_inc));
            chk({vecs[i].name, "_ehi"}, 32'(ehi), 32'(vecs[i].exp_ehi));
        end

        // glitch then clean inc_h press inside EDIT
        press_window(4'b0010, chg, inc, ehi);
        chk("enter_edit", 32'(edit), 1);
        set_btn(4'b0100);
        tick(); tick();
        set_btn(4'b0000);
        n_inc = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            n_inc += int'(inc_h);
        end
        chk("glitch_inc", 32'(n_inc), 0);
        set_btn(4'b0100);
        n_inc = 0; rise_at = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 8) set_btn(4'b0000);
            if (inc_h) begin
                n_inc++;
                rise_at = c;
            end
        end
        chk("clean_inc_cnt", 32'(n_inc), 1);
        chk("clean_inc_lat", 32'(rise_at), 8);

        // held inc_m with auto-repeat, mode press meanwhile
        set_btn(4'b1000);
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (c == 12) b_mode = 1'b1;
            if (c == 20) b_mode = 1'b0;
            if (c == 30) b_inc_m = 1'b0;
            exp_m = (c == 8) || (c >= 18 && c <= 36 && ((c - 18) % 3 == 0));
            chk($sformatf("rep_c%0d", c), 32'(inc_m), 32'(exp_m));
        end
        chk("rep_mode_hold", 32'(mode), 1);
        chk("rep_edit_hold", 32'(edit), 1);

        // exit, re-enter and let the idle timeout expire
        press_window(4'b0010, chg, inc, ehi);
        chk("exit_edit", 32'(edit), 0);
        set_btn(4'b0010);
        rise_at = 0; fall_at = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c == 8) set_btn(4'b0000);
            if (edit && rise_at == 0) rise_at = c;
            if (!edit && rise_at != 0 && fall_at == 0) fall_at = c;
        end
        chk("to_rise", 32'(rise_at), 8);
        chk("to_fall", 32'(fall_at - rise_at), 50);
        press_window(4'b0100, chg, inc, ehi);
        chk("run_inc_after_to", 32'(inc), 0);

        // reset mid-hold forces everything back at once
        set_btn(4'b0010);
        for (int c = 0; c < 10; c++) tick();
        chk("hold_edit_pre", 32'(edit), 1);
        chk("hold_mode_pre", 32'(mode), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_mode", 32'(mode), 0);
        chk("mid_rst_outs", 32'({edit, inc_h, inc_m, mode_chg}), 0);
        tick(); tick();
        reset = 1'b0;
        rise_at = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (edit && rise_at == 0) rise_at = c;
        end
        chk("held_after_rst", 32'(rise_at), 8);
        set_btn(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
